// File: rtl/dsram_req_ctrl_pkg.sv
// Shared types and constants for the data-SRAM request controller.
// The optional response buffer is enabled in dsram_req_ctrl by DSRAM_RDATA_BUF_EN.
package dsram_req_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam int MAX_OUTSTANDING = 2;

  // Saturating-free up/down step; callers guarantee the count never wraps.
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt,
                                          input logic       inc,
                                          input logic       dec);
    logic [1:0] res;
    case ({inc, dec})
      2'b10:   res = cnt + 2'd1;
      2'b01:   res = cnt - 2'd1;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dsram_resp_buf.sv
// One-entry response holding buffer between the SRAM data_ok channel and MEM.
// With BUF_EN=0 it degenerates to a pass-through and the MEM stage must consume immediately.
module dsram_resp_buf #(
  parameter bit BUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        consume,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        held
);

  logic        valid_reg;
  logic [31:0] data_reg;

  // A response arriving while the entry is full and not consumed has nowhere to go;
  // the issue limit counting the held entry keeps this from happening in normal use.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (BUF_EN) begin
      if (valid_reg) begin
        if (consume) begin
          valid_reg <= in_valid;
          if (in_valid) data_reg <= in_data;
        end
      end else if (in_valid && !consume) begin
        valid_reg <= 1'b1;
        data_reg  <= in_data;
      end
    end
  end

  always_comb begin
    out_valid = valid_reg | in_valid;
    out_data  = '0;
    if (valid_reg)     out_data = data_reg;
    else if (in_valid) out_data = in_data;
  end

  assign held = valid_reg;

endmodule

// File: rtl/dsram_req_ctrl.sv
// Data-SRAM request controller: issues EX loads/stores on an SRAM-like bus, tracks up to two
// outstanding accesses and drops responses of flushed ones. Define DSRAM_RDATA_BUF_EN for a response buffer.
module dsram_req_ctrl
  import dsram_req_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        es_mem_req,
  input  logic        es_wr,
  input  logic [1:0]  es_size,
  input  logic [31:0] es_addr,
  input  logic [3:0]  es_wstrb,
  input  logic [31:0] es_wdata,
  output logic        es_addr_ok,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_data_ok,
  output logic [31:0] ms_rdata,
  input  logic        ms_consume,
  input  logic        flush,
  output logic        busy
);

`ifdef DSRAM_RDATA_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  state_e      state_reg;
  logic        req_reg;
  logic        cancel_pending_reg;
  logic        wr_reg;
  size_e       size_reg;
  logic [31:0] addr_reg;
  logic [3:0]  wstrb_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  outstanding_reg, outstanding_next;
  logic [1:0]  cancel_cnt_reg, cancel_cnt_next;

  logic        addr_hs;
  logic        data_hs;
  logic        drop_resp;
  logic        resp_live;
  logic        buf_held;
  logic [2:0]  occupancy;
  logic        can_issue;

  assign addr_hs   = (state_reg == REQ) && data_sram_addr_ok;
  assign data_hs   = data_sram_data_ok && (outstanding_reg != 2'd0);
  assign drop_resp = data_hs && (cancel_cnt_reg != 2'd0);
  assign resp_live = data_hs && !drop_resp;

  // A response parked in the buffer still occupies one of the two slots.
  assign occupancy = {1'b0, outstanding_reg} + {2'b00, buf_held};
  assign can_issue = es_mem_req && !flush && (occupancy < 3'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      req_reg            <= 1'b0;
      cancel_pending_reg <= 1'b0;
      wr_reg             <= 1'b0;
      size_reg           <= SIZE_BYTE;
      addr_reg           <= '0;
      wstrb_reg          <= '0;
      wdata_reg          <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (can_issue) begin
            state_reg <= REQ;
            req_reg   <= 1'b1;
            wr_reg    <= es_wr;
            size_reg  <= size_e'(es_size);
            addr_reg  <= es_addr;
            wstrb_reg <= es_wstrb;
            wdata_reg <= es_wdata;
          end
        end
        REQ: begin
          // The bus request is never withdrawn; a flush only marks it cancelled.
          if (data_sram_addr_ok) begin
            state_reg          <= IDLE;
            req_reg            <= 1'b0;
            cancel_pending_reg <= 1'b0;
          end else if (flush) begin
            cancel_pending_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    outstanding_next = cnt_step(outstanding_reg, addr_hs, data_hs);
    if (flush) cancel_cnt_next = outstanding_next;
    else       cancel_cnt_next = cnt_step(cancel_cnt_reg, addr_hs && cancel_pending_reg, drop_resp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_reg <= 2'd0;
      cancel_cnt_reg  <= 2'd0;
    end else begin
      outstanding_reg <= outstanding_next;
      cancel_cnt_reg  <= cancel_cnt_next;
    end
  end

  dsram_resp_buf #(.BUF_EN(BUF_EN)) u_resp_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (resp_live),
    .in_data  (data_sram_rdata),
    .consume  (ms_consume),
    .out_valid(ms_data_ok),
    .out_data (ms_rdata),
    .held     (buf_held)
  );

  assign es_addr_ok      = addr_hs && !cancel_pending_reg;
  assign data_sram_req   = req_reg;
  assign data_sram_wr    = wr_reg;
  assign data_sram_size  = size_reg;
  assign data_sram_addr  = addr_reg;
  assign data_sram_wstrb = wstrb_reg;
  assign data_sram_wdata = wdata_reg;
  assign busy            = (outstanding_reg != 2'd0);

endmodule

// File: tb/tb_dsram_req_ctrl.sv
// Scoreboard bench for dsram_req_ctrl: access-level queue model plus a response monitor.
module tb_dsram_req_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        es_mem_req = 1'b0, es_wr = 1'b0;
  logic [1:0]  es_size = '0;
  logic [31:0] es_addr = '0, es_wdata = '0;
  logic [3:0]  es_wstrb = '0;
  logic        es_addr_ok;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = '0;
  logic        ms_data_ok;
  logic [31:0] ms_rdata;
  logic        ms_consume = 1'b0;
  logic        flush = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  dsram_req_ctrl dut (
    .clk(clk), .reset(reset),
    .es_mem_req(es_mem_req), .es_wr(es_wr), .es_size(es_size), .es_addr(es_addr),
    .es_wstrb(es_wstrb), .es_wdata(es_wdata), .es_addr_ok(es_addr_ok),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ms_data_ok(ms_data_ok), .ms_rdata(ms_rdata),
    .ms_consume(ms_consume), .flush(flush), .busy(busy)
  );

  typedef struct { bit cancelled; bit is_store; } acc_t;
  typedef struct { bit is_store; logic [31:0] data; } resp_t;

  acc_t        inflight[$];
  resp_t       exp_q[$];
  bit          p_valid = 0, p_cancel = 0, p_wr = 0;
  logic [1:0]  p_size = '0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [3:0]  p_wstrb = '0;
  bit          hold_consume = 0;
  int          req_cycles = 0;
  int          total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one pending request, an ordered list of accepted accesses, each maybe cancelled.
  task automatic model_cycle();
    int   n0;
    bit   pend0;
    acc_t head;
    if (reset) begin
      inflight.delete(); exp_q.delete();
      p_valid = 0; p_cancel = 0; ms_consume = 1'b0;
      return;
    end
    n0 = inflight.size();
    pend0 = p_valid;
    chk("busy", busy, 32'(n0 != 0));
    chk("sram_req", data_sram_req, 32'(p_valid));
    if (p_valid) begin
      req_cycles++;
      chk("sram_addr", data_sram_addr, p_addr);
      chk("sram_ctl", {data_sram_wr, data_sram_size, data_sram_wstrb}, {p_wr, p_size, p_wstrb});
      chk("sram_wdata", data_sram_wdata, p_wdata);
    end
    chk("es_addr_ok", es_addr_ok, 32'(p_valid && data_sram_addr_ok && !p_cancel));
    if (data_sram_data_ok && n0 != 0) begin
      head = inflight.pop_front();
      if (!head.cancelled) exp_q.push_back('{head.is_store, data_sram_rdata});
    end
    if (p_valid && data_sram_addr_ok) begin
      inflight.push_back('{p_cancel, p_wr});
      p_valid = 0;
    end
    if (flush) begin
      foreach (inflight[i]) inflight[i].cancelled = 1;
      if (p_valid) p_cancel = 1;
    end
    if (!pend0 && es_mem_req && !flush && n0 < 2) begin
      p_valid = 1; p_cancel = 0;
      p_wr = es_wr; p_size = es_size; p_addr = es_addr; p_wstrb = es_wstrb; p_wdata = es_wdata;
    end
    ms_consume = (exp_q.size() != 0) && !hold_consume;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("ms_data_ok", ms_data_ok, 32'(exp_q.size() != 0));
      if (ms_data_ok && exp_q.size() != 0) begin
        if (!exp_q[0].is_store) chk("ms_rdata", ms_rdata, exp_q[0].data);
        if (ms_consume) exp_q.delete(0);
      end
    end
  end

  task automatic drive(input bit mr, input bit wr, input logic [31:0] ad,
                       input bit aok, input bit dok, input logic [31:0] rd, input bit fl);
    @(posedge clk); #1;
    reset = 1'b0;
    es_mem_req = mr; es_wr = wr; es_addr = ad;
    es_size = 2'($urandom_range(0, 2)); es_wstrb = 4'($urandom); es_wdata = $urandom;
    data_sram_addr_ok = aok; data_sram_data_ok = dok; data_sram_rdata = rd; flush = fl;
    #1 model_cycle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; es_mem_req = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; flush = 1'b0;
    #1 model_cycle();
  endtask

  initial begin
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_ms_rdata", ms_rdata, 0);

    // Single load, addr_ok after two waiting cycles, data one cycle later.
    req_cycles = 0;
    drive(1, 0, 32'h1c000100, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'hdeadbeef, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t030_req_cycles", req_cycles, 3);

    // Back-to-back loads fill both slots; the third request waits for the first data_ok.
    drive(1, 0, 32'h100, 0, 0, 0, 0);
    drive(1, 0, 32'h104, 1, 0, 0, 0);
    drive(1, 0, 32'h108, 0, 0, 0, 0);
    drive(1, 0, 32'h10c, 1, 0, 0, 0);
    drive(1, 0, 32'h110, 0, 1, 32'h11111111, 0);
    chk("t031_stalled", data_sram_req, 0);
    drive(1, 0, 32'h114, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 32'h22222222, 0);
    drive(0, 0, 0, 0, 1, 32'h33333333, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Flush with one accepted access and one pending request: both responses dropped.
    drive(1, 0, 32'h200, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 32'h204, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'haaaa0001, 0);
    drive(0, 0, 0, 0, 1, 32'haaaa0002, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t032_busy", busy, 0);

    // Simultaneous accept and return keeps one access outstanding.
    drive(1, 0, 32'h300, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 32'h304, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 32'h44444444, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t033_busy", busy, 1);
    drive(0, 0, 0, 0, 1, 32'h55555555, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

`ifdef DSRAM_RDATA_BUF_EN
    drive(1, 0, 32'h400, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    hold_consume = 1;
    drive(0, 0, 0, 0, 1, 32'h12345678, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
    hold_consume = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
`endif

    // Reset while a request is on the bus.
    drive(1, 0, 32'h500, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t035_req", data_sram_req, 0);
    chk("t035_busy", busy, 0);

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 9) < 6, 1'($urandom), $urandom,
            p_valid && ($urandom_range(0, 1) == 1),
            (inflight.size() != 0) && ($urandom_range(0, 9) < 4),
            $urandom, $urandom_range(0, 19) == 0);

    for (int i = 0; i < 40 && (p_valid || inflight.size() != 0); i++)
      drive(0, 0, 0, p_valid, inflight.size() != 0, $urandom, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("drain_busy", busy, 0);
    chk("drain_req", data_sram_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
